// File: rtl/alu_ctrl_pkg.sv
// Shared constants, FSM state type and decoded control word for the ALU control sequencer.
package alu_ctrl_pkg;

  // Main-control ALU op classes
  localparam logic [3:0] AluOpRtype = 4'b0000;
  localparam logic [3:0] AluOpAddi  = 4'b0001;
  localparam logic [3:0] AluOpSltiu = 4'b0010;
  localparam logic [3:0] AluOpBeq   = 4'b0011;
  localparam logic [3:0] AluOpLui   = 4'b0100;
  localparam logic [3:0] AluOpOri   = 4'b0101;
  localparam logic [3:0] AluOpBne   = 4'b0110;
  localparam logic [3:0] AluOpLw    = 4'b0111;
  localparam logic [3:0] AluOpSw    = 4'b1000;
  localparam logic [3:0] AluOpBlez  = 4'b1001;
  localparam logic [3:0] AluOpBgtz  = 4'b1010;
  localparam logic [3:0] AluOpJ     = 4'b1011;
  localparam logic [3:0] AluOpJal   = 4'b1100;

  // R-type function fields
  localparam logic [5:0] FnAddu = 6'b100001;
  localparam logic [5:0] FnSubu = 6'b100011;
  localparam logic [5:0] FnAnd  = 6'b100100;
  localparam logic [5:0] FnOr   = 6'b100101;
  localparam logic [5:0] FnSlt  = 6'b101010;
  localparam logic [5:0] FnSra  = 6'b000011;
  localparam logic [5:0] FnSrav = 6'b000111;
  localparam logic [5:0] FnSll  = 6'b000000;
  localparam logic [5:0] FnMul  = 6'b011000;
  localparam logic [5:0] FnJr   = 6'b001000;
  localparam logic [5:0] FnDivu = 6'b011011;

  // ALU control codes
  localparam logic [4:0] CtrlAddu    = 5'd0;
  localparam logic [4:0] CtrlSubu    = 5'd1;
  localparam logic [4:0] CtrlAnd     = 5'd2;
  localparam logic [4:0] CtrlOr      = 5'd3;
  localparam logic [4:0] CtrlSlt     = 5'd4;
  localparam logic [4:0] CtrlSra     = 5'd5;
  localparam logic [4:0] CtrlSrav    = 5'd6;
  localparam logic [4:0] CtrlSll     = 5'd7;
  localparam logic [4:0] CtrlMul     = 5'd8;
  localparam logic [4:0] CtrlJr      = 5'd9;
  localparam logic [4:0] CtrlAddi    = 5'd10;
  localparam logic [4:0] CtrlSltiu   = 5'd11;
  localparam logic [4:0] CtrlBeq     = 5'd12;
  localparam logic [4:0] CtrlLui     = 5'd13;
  localparam logic [4:0] CtrlOri     = 5'd14;
  localparam logic [4:0] CtrlBne     = 5'd15;
  localparam logic [4:0] CtrlLw      = 5'd16;
  localparam logic [4:0] CtrlSw      = 5'd17;
  localparam logic [4:0] CtrlBlez    = 5'd18;
  localparam logic [4:0] CtrlBgtz    = 5'd19;
  localparam logic [4:0] CtrlJ       = 5'd20;
  localparam logic [4:0] CtrlJal     = 5'd21;
  localparam logic [4:0] CtrlDivu    = 5'd22;
  localparam logic [4:0] CtrlIllegal = 5'h1f;

  typedef struct packed {
    logic [4:0] ctrl;
    logic       reg_write;
    logic       jump;
    logic       jump_src;
    logic       multi;
    logic       illegal;
  } dec_word_t;

  typedef enum logic [1:0] {StIdle, StRun1, StBusy} state_e;

endpackage

// File: rtl/alu_ctrl_dec.sv
// Purely combinational decode of funct/ALUOp into the control word.
module alu_ctrl_dec
  import alu_ctrl_pkg::*;
(
  input  logic [5:0] funct_i,
  input  logic [3:0] ALUOp_i,
  output dec_word_t  dec_o
);

  // Start from the flagged no-op so every unlisted encoding is illegal
  always_comb begin
    dec_o = '{ctrl: CtrlIllegal, reg_write: 1'b0, jump: 1'b0, jump_src: 1'b0,
              multi: 1'b0, illegal: 1'b1};
    case (ALUOp_i)
      AluOpRtype: begin
        dec_o.illegal   = 1'b0;
        dec_o.reg_write = 1'b1;
        case (funct_i)
          FnAddu: dec_o.ctrl = CtrlAddu;
          FnSubu: dec_o.ctrl = CtrlSubu;
          FnAnd:  dec_o.ctrl = CtrlAnd;
          FnOr:   dec_o.ctrl = CtrlOr;
          FnSlt:  dec_o.ctrl = CtrlSlt;
          FnSra:  dec_o.ctrl = CtrlSra;
          FnSrav: dec_o.ctrl = CtrlSrav;
          FnSll:  dec_o.ctrl = CtrlSll;
          FnMul: begin
            dec_o.ctrl  = CtrlMul;
            dec_o.multi = 1'b1;
          end
          FnDivu: begin
            dec_o.ctrl  = CtrlDivu;
            dec_o.multi = 1'b1;
          end
          FnJr: begin
            dec_o.ctrl      = CtrlJr;
            dec_o.reg_write = 1'b0;
            dec_o.jump      = 1'b1;
            dec_o.jump_src  = 1'b1;
          end
          default: begin
            dec_o.ctrl      = CtrlIllegal;
            dec_o.reg_write = 1'b0;
            dec_o.illegal   = 1'b1;
          end
        endcase
      end
      AluOpAddi:  begin dec_o.ctrl = CtrlAddi;  dec_o.illegal = 1'b0; dec_o.reg_write = 1'b1; end
      AluOpSltiu: begin dec_o.ctrl = CtrlSltiu; dec_o.illegal = 1'b0; dec_o.reg_write = 1'b1; end
      AluOpBeq:   begin dec_o.ctrl = CtrlBeq;   dec_o.illegal = 1'b0; end
      AluOpLui:   begin dec_o.ctrl = CtrlLui;   dec_o.illegal = 1'b0; dec_o.reg_write = 1'b1; end
      AluOpOri:   begin dec_o.ctrl = CtrlOri;   dec_o.illegal = 1'b0; dec_o.reg_write = 1'b1; end
      AluOpBne:   begin dec_o.ctrl = CtrlBne;   dec_o.illegal = 1'b0; end
      AluOpLw:    begin dec_o.ctrl = CtrlLw;    dec_o.illegal = 1'b0; dec_o.reg_write = 1'b1; end
      AluOpSw:    begin dec_o.ctrl = CtrlSw;    dec_o.illegal = 1'b0; end
      AluOpBlez:  begin dec_o.ctrl = CtrlBlez;  dec_o.illegal = 1'b0; end
      AluOpBgtz:  begin dec_o.ctrl = CtrlBgtz;  dec_o.illegal = 1'b0; end
      AluOpJ:     begin dec_o.ctrl = CtrlJ;     dec_o.illegal = 1'b0; dec_o.jump = 1'b1; end
      AluOpJal: begin
        dec_o.ctrl      = CtrlJal;
        dec_o.illegal   = 1'b0;
        dec_o.reg_write = 1'b1;
        dec_o.jump      = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_ctrl_seq.sv
// Registered ALU control with multi-cycle sequencing for MUL/DIVU.
module alu_ctrl_seq
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned CTRL_W     = 5,
  parameter int unsigned MUL_CYCLES = 4,
  parameter int unsigned DIV_CYCLES = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic [5:0]        funct_i,
  input  logic [3:0]        ALUOp_i,
  input  logic              flush_i,
  output logic              stall_o,
  output logic              valid_o,
  output logic [CTRL_W-1:0] ALUCtrl_o,
  output logic              RegWrite2,
  output logic              Jump2,
  output logic              JumpSrc,
  output logic              mc_start_o,
  output logic              illegal_o
);

  localparam int unsigned MaxCycles = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;
  localparam logic [CntW-1:0] MulLoad = CntW'(MUL_CYCLES - 1);
  localparam logic [CntW-1:0] DivLoad = CntW'(DIV_CYCLES - 1);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  dec_word_t       word_q, word_d, dec;
  logic            mc_start_q, mc_start_d;
  logic            accept;

  alu_ctrl_dec u_dec (
    .funct_i (funct_i),
    .ALUOp_i (ALUOp_i),
    .dec_o   (dec)
  );

  // Handshake outputs decode registered state only
  assign stall_o = (state_q == StBusy) && (cnt_q != '0);
  assign valid_o = (state_q == StRun1) || ((state_q == StBusy) && (cnt_q == '0));
  assign accept  = valid_i & ~stall_o & ~flush_i;

  assign ALUCtrl_o  = word_q.illegal ? {CTRL_W{1'b1}} : CTRL_W'(word_q.ctrl);
  assign RegWrite2  = valid_o & word_q.reg_write;
  assign Jump2      = valid_o & word_q.jump;
  assign JumpSrc    = valid_o & word_q.jump_src;
  assign illegal_o  = valid_o & word_q.illegal;
  assign mc_start_o = mc_start_q;

  // Next state: flush wins, then accept, then count down, else fall back to idle
  always_comb begin
    state_d    = StIdle;
    cnt_d      = '0;
    word_d     = word_q;
    mc_start_d = 1'b0;
    if (flush_i) begin
      state_d = StIdle;
    end else if (accept) begin
      word_d     = dec;
      mc_start_d = dec.multi;
      if (dec.multi) begin
        state_d = StBusy;
        cnt_d   = (dec.ctrl == CtrlDivu) ? DivLoad : MulLoad;
      end else begin
        state_d = StRun1;
      end
    end else if (stall_o) begin
      state_d = StBusy;
      cnt_d   = cnt_q - 1'b1;
    end
  end

  // State, counter and output registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      word_q     <= '0;
      mc_start_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      word_q     <= word_d;
      mc_start_q <= mc_start_d;
    end
  end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Directed bench with a cycle-level reference model for alu_ctrl_seq.
module tb_alu_ctrl_seq;

  localparam int MulN = 4;
  localparam int DivN = 8;

  logic       clk, rst, valid, flush;
  logic [5:0] funct;
  logic [3:0] aluop;
  logic       stall_o, valid_o, reg_write, jump, jump_src, mc_start, illegal;
  logic [4:0] ctrl;

  int n_checks = 0;
  int n_errs   = 0;

  alu_ctrl_seq #(
    .CTRL_W     (5),
    .MUL_CYCLES (MulN),
    .DIV_CYCLES (DivN)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .valid_i    (valid),
    .funct_i    (funct),
    .ALUOp_i    (aluop),
    .flush_i    (flush),
    .stall_o    (stall_o),
    .valid_o    (valid_o),
    .ALUCtrl_o  (ctrl),
    .RegWrite2  (reg_write),
    .Jump2      (jump),
    .JumpSrc    (jump_src),
    .mc_start_o (mc_start),
    .illegal_o  (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference decode straight from the opcode tables
  function automatic void mdl_dec(input logic [5:0] f, input logic [3:0] op, output int code,
                                  output bit rw, output bit j, output bit js, output bit mu,
                                  output bit il);
    code = 31; rw = 0; j = 0; js = 0; mu = 0; il = 0;
    if (op >= 4'd1 && op <= 4'd12) begin
      code = 9 + int'(op);
      rw   = (op == 4'd1 || op == 4'd2 || op == 4'd4 || op == 4'd5 || op == 4'd7 || op == 4'd12);
      j    = (op == 4'd11 || op == 4'd12);
    end else if (op == 4'd0) begin
      rw = 1;
      case (f)
        6'b100001: code = 0;
        6'b100011: code = 1;
        6'b100100: code = 2;
        6'b100101: code = 3;
        6'b101010: code = 4;
        6'b000011: code = 5;
        6'b000111: code = 6;
        6'b000000: code = 7;
        6'b011000: begin code = 8; mu = 1; end
        6'b001000: begin code = 9; rw = 0; j = 1; js = 1; end
        6'b011011: begin code = 22; mu = 1; end
        default:   begin code = 31; rw = 0; il = 1; end
      endcase
    end else begin
      il = 1;
    end
  endfunction

  // Model: m_left = cycles until the in-flight result has been shown (1 = showing now)
  int m_left = 0;
  int m_code = 0;
  bit m_rw = 0, m_j = 0, m_js = 0, m_ill = 0, m_mc = 0, chk_en = 0;
  int d_code;
  bit d_rw, d_j, d_js, d_mu, d_il;

  always @(posedge clk) begin
    if (rst) begin
      m_left = 0; m_code = 0; m_rw = 0; m_j = 0; m_js = 0; m_ill = 0; m_mc = 0;
      chk_en = 1;
    end else if (flush) begin
      m_left = 0; m_mc = 0;
    end else if (valid && !(m_left > 1)) begin
      mdl_dec(funct, aluop, d_code, d_rw, d_j, d_js, d_mu, d_il);
      m_code = d_code; m_rw = d_rw; m_j = d_j; m_js = d_js; m_ill = d_il; m_mc = d_mu;
      m_left = !d_mu ? 1 : ((d_code == 22) ? DivN : MulN);
    end else begin
      if (m_left > 0) m_left = m_left - 1;
      m_mc = 0;
    end
  end

  // Per-cycle comparison of every output against the model
  logic [11:0] act_v, exp_v;
  bit          ev;
  int          cyc = 0;
  always @(negedge clk) begin
    if (chk_en) begin
      cyc++;
      ev    = (m_left == 1);
      exp_v = {m_left > 1, ev, m_code[4:0], ev & m_rw, ev & m_j, ev & m_js, m_mc, ev & m_ill};
      act_v = {stall_o, valid_o, ctrl, reg_write, jump, jump_src, mc_start, illegal};
      n_checks++;
      if (act_v !== exp_v) begin
        n_errs++;
        $display("FAIL model cycle %0d: got %03h expected %03h", cyc, act_v, exp_v);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [5:0] f, input logic [3:0] op, input bit fl);
    valid = v; funct = f; aluop = op; flush = fl;
  endtask

  int n;

  initial begin
    rst = 1; drive(0, 6'd0, 4'd0, 0);
    tick(); tick();
    rst = 0;
    tick();
    chk("reset valid", int'(valid_o), 0);
    chk("reset stall", int'(stall_o), 0);
    chk("reset ctrl", int'(ctrl), 0);
    chk("reset mc_start", int'(mc_start), 0);

    // Back-to-back single-cycle ops
    drive(1, 6'b100001, 4'd0, 0); tick();
    chk("addu valid", int'(valid_o), 1);
    chk("addu ctrl", int'(ctrl), 0);
    chk("addu regwrite", int'(reg_write), 1);
    drive(1, 6'b001000, 4'd0, 0); tick();
    chk("jr ctrl", int'(ctrl), 9);
    chk("jr jump/src/rw", int'({jump, jump_src, reg_write}), 3'b110);
    drive(1, 6'd0, 4'b1100, 0); tick();
    chk("jal ctrl", int'(ctrl), 21);
    chk("jal rw/jump/src", int'({reg_write, jump, jump_src}), 3'b110);
    drive(0, 6'd0, 4'd0, 0); tick();
    chk("hold ctrl", int'(ctrl), 21);
    chk("hold quals off", int'({valid_o, reg_write, jump}), 0);

    // MUL followed by SUBU held on the input
    drive(1, 6'b011000, 4'd0, 0); tick();
    chk("mul start", int'({mc_start, stall_o, valid_o}), 3'b110);
    drive(1, 6'b100011, 4'd0, 0); tick();
    chk("mul stall2", int'({mc_start, stall_o}), 2'b01);
    tick();
    chk("mul stall3", int'(stall_o), 1);
    tick();
    chk("mul result", int'({stall_o, valid_o}), 2'b01);
    chk("mul ctrl", int'(ctrl), 8);
    tick();
    chk("subu after mul", int'({valid_o, ctrl}), {1'b1, 5'd1});
    drive(0, 6'd0, 4'd0, 0); tick();

    // Full DIVU latency
    drive(1, 6'b011011, 4'd0, 0); tick();
    drive(0, 6'd0, 4'd0, 0);
    n = 0;
    while (valid_o !== 1'b1 && n < 20) begin tick(); n++; end
    chk("divu latency", n, DivN - 1);
    chk("divu ctrl", int'(ctrl), 22);
    tick();

    // DIVU flushed mid-flight
    drive(1, 6'b011011, 4'd0, 0); tick();
    drive(0, 6'd0, 4'd0, 0); tick(); tick();
    drive(0, 6'd0, 4'd0, 1); tick();
    chk("flush stall", int'(stall_o), 0);
    chk("flush valid", int'(valid_o), 0);
    drive(0, 6'd0, 4'd0, 0);
    for (int i = 0; i < DivN; i++) tick();
    drive(1, 6'd0, 4'b0101, 0); tick();
    chk("ori after flush", int'({valid_o, ctrl, reg_write}), {1'b1, 5'd14, 1'b1});
    drive(0, 6'd0, 4'd0, 0); tick();

    // Illegal encodings
    drive(1, 6'b111111, 4'd0, 0); tick();
    chk("illegal funct", int'({valid_o, illegal, ctrl}), {2'b11, 5'h1f});
    chk("illegal funct quals", int'({reg_write, jump, jump_src}), 0);
    drive(1, 6'd0, 4'b1110, 0); tick();
    chk("illegal aluop", int'({valid_o, illegal, ctrl}), {2'b11, 5'h1f});
    drive(0, 6'd0, 4'd0, 0); tick();
    chk("illegal drop", int'(illegal), 0);

    // Reset during MUL busy
    drive(1, 6'b011000, 4'd0, 0); tick();
    drive(0, 6'd0, 4'd0, 0); tick();
    rst = 1; tick();
    chk("reset mid-op", int'({stall_o, valid_o, ctrl, mc_start}), 0);
    rst = 0; tick(); tick();
    drive(1, 6'd0, 4'b0001, 0); tick();
    chk("addi after reset", int'({valid_o, ctrl, reg_write}), {1'b1, 5'd10, 1'b1});
    drive(0, 6'd0, 4'd0, 0); tick(); tick();

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_seq.md
# alu_ctrl_seq

Parametrised, registered successor to the single-cycle ALU control decoder. It decodes `funct_i`/`ALUOp_i` into the ALU control code plus the RegWrite, Jump and JumpSrc qualifiers, and registers them into the EX stage. It adds multi-cycle sequencing for MUL and the new DIVU: a down-counter holds the op and stalls upstream until the result slot. Unknown encodings produce a defined, flagged no-op instead of holding stale values.

## Interface
- `CTRL_W`, default 5: ALU control width, must be ≥5; codes are zero-extended.
- `MUL_CYCLES`, default 4: MUL occupancy in cycles, must be ≥1.
- `DIV_CYCLES`, default 8: DIVU occupancy in cycles, must be ≥1.
- `clk_i`, in, 1: the only clock.
- `rst_i`, in, 1: reset, synchronous and active-high.
- `valid_i`, in, 1: the decode stage presents an instruction.
- `funct_i`, in, 6: R-type function field.
- `ALUOp_i`, in, 4: main-control ALU op class.
- `flush_i`, in, 1: kill the in-flight op (branch/jump redirect).
- `stall_o`, out, 1: upstream must hold its instruction.
- `valid_o`, out, 1: the control word is valid this cycle.
- `ALUCtrl_o`, out, CTRL_W: ALU operation code.
- `RegWrite2`, out, 1: register write enable, gated by `valid_o`.
- `Jump2`, out, 1: jump taken, gated by `valid_o`.
- `JumpSrc`, out, 1: jump target source (1 = register), gated by `valid_o`.
- `mc_start_o`, out, 1: one-cycle start pulse to the multi-cycle unit.
- `illegal_o`, out, 1: unknown encoding, pulses with `valid_o`.

## Operation
- **R-type, ALUOp 0000.** Code, then RegWrite/Jump/JumpSrc:
  - ADDU 100001 → 0, 1/0/0
  - SUBU 100011 → 1, 1/0/0
  - AND 100100 → 2, 1/0/0
  - OR 100101 → 3, 1/0/0
  - SLT 101010 → 4, 1/0/0
  - SRA 000011 → 5, 1/0/0
  - SRAV 000111 → 6, 1/0/0
  - SLL 000000 → 7, 1/0/0
  - MUL 011000 → 8, 1/0/0
  - JR 001000 → 9, 0/1/1
  - DIVU 011011 → 22, 1/0/0
- **ALUOp 0001–1100** map, in order, to codes 10–21: ADDI, SLTIU, BEQ, LUI, ORI, BNE, LW, SW, BLEZ, BGTZ, J, JAL.
  - RegWrite=1 for ADDI, SLTIU, LUI, ORI, LW, JAL.
  - Jump=1 for J and JAL.
  - JumpSrc=0 for all of these.
- **Illegal encodings** (undefined funct under 0000, or ALUOp 1101–1111): code all-ones, RegWrite/Jump/JumpSrc=0, `illegal_o`=1.
- **Accept.** An instruction is accepted at a rising edge when `valid_i & ~stall_o & ~flush_i`.
- **FSM states:**
  - IDLE:
    - Single-cycle op accepted → RUN1.
    - MUL/DIVU accepted → BUSY with `cnt` = N−1 (N = MUL_CYCLES or DIV_CYCLES).
    - Nothing accepted → stay in IDLE.
  - RUN1: `valid_o`=1 for one cycle. The next instruction may be accepted at the same edge, giving back-to-back throughput of 1/cycle.
  - BUSY: `cnt` decrements each cycle.
    - `stall_o` = (`cnt` ≠ 0).
    - `valid_o` = (`cnt` = 0).
    - At the `cnt`=0 edge, a new accept is allowed with the same transitions as IDLE; otherwise the next state is IDLE.
- `cnt` width is clog2(max(MUL_CYCLES, DIV_CYCLES)), minimum 1 bit.
- **Hold.** `ALUCtrl_o` holds its value through BUSY and after `valid_o` drops. The qualifiers are 0 whenever `valid_o`=0.
- **Flush.** `flush_i` overrides everything: next state IDLE, `cnt`=0, `valid_o`=0 and `stall_o`=0 next cycle. No instruction is accepted on a flush edge.
- **Reset.** While `rst_i`=1 at an edge: state IDLE, `cnt`=0, all outputs 0 (including `ALUCtrl_o`). Reset mid-BUSY aborts the op with no `valid_o`.

## Timing
- Single-cycle op accepted at edge k: `valid_o` is high in cycle k→k+1.
- MUL/DIVU accepted at edge k:
  - `mc_start_o` is high in cycle k→k+1.
  - `stall_o` is high for cycles k..k+N−2.
  - `valid_o` is high in cycle k+N−1→k+N.
- N=1 behaves identically to a single-cycle op, with `mc_start_o` still pulsed.
- `stall_o` is a registered-state decode: no combinational path from `valid_i`/`funct_i`. A combinational path from `flush_i` to `stall_o` is not allowed.

## Structure
- Package `alu_ctrl_pkg` holds:
  - ALUOp constants;
  - funct constants;
  - ALU control code constants 0–22 plus ILLEGAL;
  - a decoded-word struct {ctrl, reg_write, jump, jump_src, multi, illegal}.
- One sub-module, `alu_ctrl_dec`: the purely combinational decode to that struct, with full default assignment so no latches are inferred. `alu_ctrl_seq` holds the FSM, counter and output registers.

## Test plan
- **Reset/idle:** `rst_i`=1 for 2 cycles, then `valid_i`=0 → all outputs 0, `stall_o`=0.
- **Back-to-back single-cycle:** ADDU, JR, then ALUOp 1100 on consecutive cycles → `valid_o` on 3 consecutive cycles with:
  - code 0, RegWrite 1;
  - code 9, Jump 1, JumpSrc 1;
  - code 21, RegWrite 1, Jump 1.
- **MUL with MUL_CYCLES=4:**
  - MUL then SUBU held on input → `mc_start_o` 1 cycle.
  - `stall_o` 3 cycles, then MUL `valid_o` with code 8 on the 4th cycle.
  - SUBU accepted on that edge, code 1 valid the following cycle.
- **DIVU flushed:** DIVU with DIV_CYCLES=8, `flush_i` pulsed 3 cycles after accept → no `valid_o` for DIVU; `stall_o`=0 the next cycle; the next ORI yields code 14.
- **Illegal encodings:** funct 111111 under ALUOp 0000, and ALUOp 1110 → `valid_o`=1, `illegal_o`=1, code 11111, qualifiers 0.
- **Reset mid-op:** reset during MUL BUSY → outputs 0 the next cycle, no `valid_o` for MUL, normal accept afterwards.
